tx_byte_feeder: RTL and testbench
=================================

TX_BYTE_FEEDER -- requirements
Module: tx_byte_feeder

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries; power of two, 2..256.
REQ-002 SHALL have parameter SEND_HOLD, default 2, clk cycles `send` is held high per byte, 1..15.
REQ-003 SHALL have parameter BUSY_TIMEOUT, default 64, cycles to wait for `port_available` low before retrying, 2..255.
REQ-004 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port wr_en  input  1  push `wr_data` this cycle.
REQ-007 SHALL have port wr_data  input  8  byte from cartridge read path.
REQ-008 SHALL have port full  output  1  FIFO holds DEPTH bytes.
REQ-009 SHALL have port empty  output  1  FIFO holds 0 bytes.
REQ-010 SHALL have port count  output  log2(DEPTH)+1  bytes currently stored (excluding the byte in flight).
REQ-011 SHALL have port tx_data  output  8  byte presented to the UART transmitter.
REQ-012 SHALL have port send  output  1  transmit request to the UART; the UART acts on its rising edge.
REQ-013 SHALL have port port_available  input  1  UART status; 0 while framing a byte, 1 once the stop bit is done.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-015 SHALL store `wr_data` at the tail when wr_en=1 and full=0; count increments at that edge.
REQ-016 SHALL silently drop the write when wr_en=1 and full=1; a pop in the same cycle does not free a slot for it.
REQ-017 SHALL, on a simultaneous accepted push and pop, leave count unchanged and keep the data correct.
REQ-018 SHALL wrap read/write pointers modulo DEPTH; full and empty derive from count only.
REQ-019 SHALL implement FSM states IDLE, SEND, WAIT_BUSY, WAIT_FREE.
REQ-020 SHALL, in IDLE with empty=0, pop the head into tx_data and enter SEND at the same edge; port_available is ignored in IDLE.
REQ-021 SHALL drive send=1 exactly in SEND, for SEND_HOLD cycles, then enter WAIT_BUSY.
REQ-022 SHALL, in WAIT_BUSY, enter WAIT_FREE on the first edge sampling port_available=0.
REQ-023 SHALL, if port_available stays 1 for BUSY_TIMEOUT cycles in WAIT_BUSY, re-enter SEND with tx_data unchanged, which retries the same byte.
REQ-024 SHALL, in WAIT_FREE, return to IDLE on the first edge sampling port_available=1; treat X/0 as busy.
REQ-025 SHALL hold tx_data stable from entry to SEND until the next pop.
REQ-026 SHALL guarantee send is low for at least one cycle between consecutive SEND periods.
REQ-027 SHALL raise send one cycle after a byte is written to an empty FIFO while the FSM is in IDLE.
REQ-028 SHALL accept writes in every FSM state.

Reset
REQ-029 SHALL, while rst=1 (asynchronously), force state=IDLE, pointers=0, count=0, empty=1, full=0, tx_data=8'h00, send=0, busy=0.
REQ-030 SHALL, on reset mid-transfer, discard the in-flight byte and all stored bytes; send drops immediately.
REQ-031 SHALL leave the memory array contents unreset.

Configuration
REQ-032 SHALL, with FEEDER_OVERFLOW_FLAG_EN defined, add output `overflow` (1 bit), set sticky on any dropped write and cleared only by rst.
REQ-033 SHALL, without FEEDER_OVERFLOW_FLAG_EN, omit the `overflow` port; drop behaviour is otherwise identical.

Verification
REQ-034 SHALL cover: rst=1 then release, no writes -> send=0, empty=1, count=0, tx_data=8'h00 for 100 cycles.
REQ-035 SHALL cover: write 8'hA5 with a UART model (busy 10 cycles after the send edge) -> send high 2 cycles with tx_data=8'hA5, then IDLE; one byte is transmitted.
REQ-036 SHALL cover: write 20 bytes 8'h00..8'h13 back-to-back with DEPTH=16 and the UART busy -> bytes 8'h00..8'h10 are transmitted in order (one is in flight); the rest are dropped; overflow=1 when the macro is defined.
REQ-037 SHALL cover: a UART model that never drops port_available -> send re-pulses every SEND_HOLD+BUSY_TIMEOUT cycles with the same tx_data.
REQ-038 SHALL cover: rst asserted during WAIT_FREE with 5 bytes stored -> send=0, count=0, and no further send after release.
REQ-039 SHALL cover: full FIFO with a push and pop in the same cycle -> the write is dropped and count goes DEPTH to DEPTH-1.

Source files
------------

// File: rtl/tx_byte_feeder.sv
// -----------------------------------------------------------------------------
// tx_byte_feeder
//
// Byte FIFO between the cartridge read path and a UART transmitter. Bytes are
// pushed with wr_en/wr_data. A small FSM pops one byte at a time, holds `send`
// high for SEND_HOLD cycles, and waits for the UART to report a complete frame
// on port_available.
//
// Handshake with the UART:
//   IDLE      -> pop the head byte into tx_data, then go to SEND.
//   SEND      -> send=1 for SEND_HOLD cycles.
//   WAIT_BUSY -> wait for the UART to drop port_available. If it stays high
//                for BUSY_TIMEOUT cycles, the request was missed and the same
//                byte is sent again.
//   WAIT_FREE -> wait for port_available=1, which means the stop bit is done.
//
// Parameters:
//   DEPTH        FIFO entries. Power of two, 2..256.
//   SEND_HOLD    cycles `send` stays high per attempt, 1..15.
//   BUSY_TIMEOUT cycles to wait for port_available low before retrying, 2..255.
//
// Optional feature:
//   `define FEEDER_OVERFLOW_FLAG_EN adds a sticky `overflow` output. It is set
//   by any dropped write and cleared only by rst.
//   Without the macro the port is absent. Writes to a full FIFO are still
//   dropped in the same way.
// -----------------------------------------------------------------------------
module tx_byte_feeder #(
    parameter int DEPTH        = 16,
    parameter int SEND_HOLD    = 2,
    parameter int BUSY_TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [7:0]               tx_data,
    output logic                     send,
    input  logic                     port_available,
    output logic                     busy
`ifdef FEEDER_OVERFLOW_FLAG_EN
    ,
    output logic                     overflow
`endif
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;
    localparam int CNT_W = 8;

    localparam logic [AW-1:0]    PTR_ONE      = AW'(1);
    localparam logic [CW-1:0]    CNT_ONE      = CW'(1);
    localparam logic [CW-1:0]    DEPTH_CNT    = CW'(DEPTH);
    localparam logic [CNT_W-1:0] TMR_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(SEND_HOLD - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(BUSY_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_FREE = 2'd3
    } state_t;

    // FIFO storage and bookkeeping.
    logic [7:0]       mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;

    // Transmit FSM state and registered outputs.
    state_t           state_q;
    logic [CNT_W-1:0] tmr_q;
    logic [7:0]       tx_data_q;
    logic             send_q;
    logic             busy_q;

    logic             is_full;
    logic             is_empty;
    logic             push;
    logic             pop;

    // Full and empty come from the occupancy count only, never from pointer
    // comparison, so the pointers can wrap freely.
    assign is_full  = (count_q == DEPTH_CNT);
    assign is_empty = (count_q == '0);

    // Acceptance looks only at the current full flag. A pop in the same cycle
    // does not make room for a write that arrives while the FIFO is full.
    assign push = wr_en && !is_full;
    assign pop  = (state_q == IDLE) && !is_empty;

    // FIFO pointer and occupancy next-state.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can
        // leave it unassigned and infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // FIFO pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments only. All of them
        // then update together at the edge, whatever order the blocks run in.
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Byte storage, written at the tail on every accepted push.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset on purpose. The count and pointers say
        // which entries are valid, and an unreset array can map onto RAM.
        if (push) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    // Transmit FSM: pop, hold send, then wait for the UART busy/free cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            tmr_q     <= '0;
            tx_data_q <= 8'h00;
            send_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // port_available is ignored here. The previous frame was
                    // already confirmed complete in WAIT_FREE.
                    if (pop) begin
                        tx_data_q <= mem[rd_ptr_q];
                        state_q   <= SEND;
                        tmr_q     <= '0;
                        send_q    <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end

                SEND: begin
                    if (tmr_q == HOLD_LAST) begin
                        state_q <= WAIT_BUSY;
                        tmr_q   <= '0;
                        send_q  <= 1'b0;
                    end else begin
                        tmr_q <= tmr_q + TMR_ONE;
                    end
                end

                WAIT_BUSY: begin
                    // The UART dropping port_available confirms it took the
                    // byte. A timeout means the request was missed, so the byte
                    // in tx_data is sent again. send has already been low for
                    // at least one cycle, so the UART sees a fresh rising edge.
                    if (!port_available) begin
                        state_q <= WAIT_FREE;
                        tmr_q   <= '0;
                    end else if (tmr_q == TIMEOUT_LAST) begin
                        state_q <= SEND;
                        tmr_q   <= '0;
                        send_q  <= 1'b1;
                    end else begin
                        tmr_q <= tmr_q + TMR_ONE;
                    end
                end

                WAIT_FREE: begin
                    // Only a definite 1 counts as free. A 0 or X keeps waiting.
                    if (port_available == 1'b1) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q <= IDLE;
                    tmr_q   <= '0;
                    send_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef FEEDER_OVERFLOW_FLAG_EN
    logic overflow_q;

    // Sticky record of any write lost to a full FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else if (wr_en && is_full) begin
            overflow_q <= 1'b1;
        end
    end

    assign overflow = overflow_q;
`endif

    assign full    = is_full;
    assign empty   = is_empty;
    assign count   = count_q;
    assign tx_data = tx_data_q;
    assign send    = send_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_tx_byte_feeder.sv
// -----------------------------------------------------------------------------
// Testbench for tx_byte_feeder.
//
// A behavioural UART model runs alongside the DUT. It records every byte that
// `send` requests and the width of each send pulse, and it drives
// port_available in one of three modes: normal (busy for busy_len cycles after
// each request), never busy, or stuck busy.
//
// Expected transmit sequences are built from the written bytes and the FIFO
// capacity rules.
// -----------------------------------------------------------------------------
module tb_tx_byte_feeder;

    localparam int DEPTH        = 16;
    localparam int SEND_HOLD    = 2;
    localparam int BUSY_TIMEOUT = 64;
    localparam int CW           = $clog2(DEPTH) + 1;

    logic          clk;
    logic          rst;
    logic          wr_en;
    logic [7:0]    wr_data;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic [7:0]    tx_data;
    logic          send;
    logic          port_available;
    logic          busy;
`ifdef FEEDER_OVERFLOW_FLAG_EN
    logic          overflow;
`endif

    tx_byte_feeder #(
        .DEPTH        (DEPTH),
        .SEND_HOLD    (SEND_HOLD),
        .BUSY_TIMEOUT (BUSY_TIMEOUT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .wr_en          (wr_en),
        .wr_data        (wr_data),
        .full           (full),
        .empty          (empty),
        .count          (count),
        .tx_data        (tx_data),
        .send           (send),
        .port_available (port_available),
        .busy           (busy)
`ifdef FEEDER_OVERFLOW_FLAG_EN
        ,
        .overflow       (overflow)
`endif
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef enum int {U_NORMAL, U_NEVER, U_STUCK} umode_t;
    umode_t     umode    = U_NORMAL;
    int         busy_len = 10;
    int         busy_left = 0;
    logic       prev_send = 1'b0;
    int         last_rise = 0;
    logic [7:0] rx_q[$];
    int         rise_q[$];
    int         width_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    // UART model. It samples 2 time units after each rising edge, so the DUT
    // outputs have settled and port_available changes well before the next edge.
    always begin
        @(posedge clk);
        #2;
        if (rst) begin
            prev_send      = 1'b0;
            busy_left      = 0;
            port_available = (umode != U_STUCK);
        end else begin
            if (send && !prev_send) begin
                rx_q.push_back(tx_data);
                rise_q.push_back(cyc);
                last_rise = cyc;
                if (umode == U_NORMAL) busy_left = busy_len;
            end
            if (!send && prev_send) width_q.push_back(cyc - last_rise);
            prev_send = send;
            case (umode)
                U_NEVER: port_available = 1'b1;
                U_STUCK: port_available = 1'b0;
                default: begin
                    if (busy_left > 0) begin
                        port_available = 1'b0;
                        busy_left--;
                    end else begin
                        port_available = 1'b1;
                    end
                end
            endcase
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic clear_logs();
        rx_q.delete();
        rise_q.delete();
        width_q.delete();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst   = 1'b1;
        wr_en = 1'b0;
        repeat (2) @(negedge clk);
        clear_logs();
        rst = 1'b0;
    endtask

    // Write bytes back-to-back, one per cycle, then leave wr_en low.
    task automatic write_burst(input logic [7:0] bytes[$]);
        foreach (bytes[i]) begin
            @(negedge clk);
            wr_en   = 1'b1;
            wr_data = bytes[i];
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Wait until the UART has seen n requests, within a cycle budget.
    task automatic wait_rx(input int n, input int budget, input string tag);
        int waited = 0;
        while (rx_q.size() < n && waited < budget) begin
            @(negedge clk);
            waited++;
        end
        n_vec++;
        if (rx_q.size() < n) begin
            n_err++;
            $display("FAIL %s_timeout: saw %0d transmitted bytes, required %0d", tag, rx_q.size(), n);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            n_vec++;
            if (send !== 1'b0 || empty !== 1'b1 || count !== '0 || tx_data !== 8'h00 ||
                busy !== 1'b0 || full !== 1'b0) begin
                n_err++;
                $display("FAIL reset_idle cyc %0d: send=%b empty=%b count=%0d tx_data=%h busy=%b full=%b, required 0 1 0 00 0 0",
                         i, send, empty, count, tx_data, busy, full);
            end
        end
`ifdef FEEDER_OVERFLOW_FLAG_EN
        n_vec++;
        if (overflow !== 1'b0) begin
            n_err++;
            $display("FAIL reset_overflow: got %b, required 0", overflow);
        end
`endif
    endtask

    task automatic test_single_byte();
        logic [7:0] one[$];
        int waited = 0;
        umode    = U_NORMAL;
        busy_len = 10;
        apply_reset();
        one = '{8'hA5};
        @(negedge clk);
        wr_en   = 1'b1;
        wr_data = 8'hA5;
        @(negedge clk);
        wr_en = 1'b0;
        n_vec++;
        if (send !== 1'b0 || count !== CW'(1) || empty !== 1'b0) begin
            n_err++;
            $display("FAIL single_stored: send=%b count=%0d empty=%b, required 0 1 0", send, count, empty);
        end
        @(negedge clk);
        n_vec++;
        if (send !== 1'b1 || tx_data !== one[0] || busy !== 1'b1 || count !== '0) begin
            n_err++;
            $display("FAIL single_send_rise: send=%b tx_data=%h busy=%b count=%0d, required 1 a5 1 0",
                     send, tx_data, busy, count);
        end
        @(negedge clk);
        n_vec++;
        if (send !== 1'b1 || tx_data !== 8'hA5) begin
            n_err++;
            $display("FAIL single_send_hold: send=%b tx_data=%h, required 1 a5", send, tx_data);
        end
        @(negedge clk);
        n_vec++;
        if (send !== 1'b0) begin
            n_err++;
            $display("FAIL single_send_fall: send=%b, required 0", send);
        end
        while (busy !== 1'b0 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL single_idle_timeout: busy=%b after %0d cycles, required 0", busy, waited);
        end
        repeat (30) @(negedge clk);
        n_vec++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'hA5 || width_q.size() < 1 || width_q[0] != SEND_HOLD) begin
            n_err++;
            $display("FAIL single_tx: %0d bytes first=%h width=%0d, required 1 byte a5 width %0d",
                     rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'h00,
                     (width_q.size() > 0) ? width_q[0] : -1, SEND_HOLD);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] bytes[$];
        umode = U_STUCK;
        apply_reset();
        for (int i = 0; i < 20; i++) bytes.push_back(8'(i));
        write_burst(bytes);
        n_vec++;
        if (count !== CW'(DEPTH) || full !== 1'b1 || empty !== 1'b0 || busy !== 1'b1 || rx_q.size() != 1) begin
            n_err++;
            $display("FAIL overflow_full: count=%0d full=%b empty=%b busy=%b sent=%0d, required %0d 1 0 1 1",
                     count, full, empty, busy, rx_q.size(), DEPTH);
        end
`ifdef FEEDER_OVERFLOW_FLAG_EN
        n_vec++;
        if (overflow !== 1'b1) begin
            n_err++;
            $display("FAIL overflow_flag: got %b, required 1", overflow);
        end
`endif
        umode    = U_NORMAL;
        busy_len = 10;
        wait_rx(DEPTH + 1, (DEPTH + 1) * 40, "overflow_drain");
        repeat (40) @(negedge clk);
        // One byte was in flight and DEPTH bytes were stored. Bytes DEPTH+1 and
        // later were dropped.
        n_vec++;
        if (rx_q.size() != DEPTH + 1) begin
            n_err++;
            $display("FAIL overflow_count: %0d bytes sent, required %0d", rx_q.size(), DEPTH + 1);
        end
        for (int i = 0; i < rx_q.size() && i <= DEPTH; i++) begin
            n_vec++;
            if (rx_q[i] !== 8'(i)) begin
                n_err++;
                $display("FAIL overflow_order idx %0d: got %h, required %h", i, rx_q[i], 8'(i));
            end
        end
        n_vec++;
        if (empty !== 1'b1 || count !== '0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL overflow_drained: empty=%b count=%0d busy=%b, required 1 0 0", empty, count, busy);
        end
    endtask

    task automatic test_timeout_retry();
        logic [7:0] b;
        umode = U_NEVER;
        apply_reset();
        b = 8'($urandom_range(0, 255));
        @(negedge clk);
        wr_en   = 1'b1;
        wr_data = b;
        @(negedge clk);
        wr_en = 1'b0;
        wait_rx(3, 4 * (SEND_HOLD + BUSY_TIMEOUT), "retry");
        for (int i = 0; i < rx_q.size() && i < 3; i++) begin
            n_vec++;
            if (rx_q[i] !== b) begin
                n_err++;
                $display("FAIL retry_data idx %0d: got %h, required %h", i, rx_q[i], b);
            end
        end
        for (int i = 1; i < rise_q.size() && i < 3; i++) begin
            n_vec++;
            if (rise_q[i] - rise_q[i-1] != SEND_HOLD + BUSY_TIMEOUT) begin
                n_err++;
                $display("FAIL retry_period idx %0d: got %0d cycles, required %0d",
                         i, rise_q[i] - rise_q[i-1], SEND_HOLD + BUSY_TIMEOUT);
            end
        end
        for (int i = 0; i < width_q.size() && i < 2; i++) begin
            n_vec++;
            if (width_q[i] != SEND_HOLD) begin
                n_err++;
                $display("FAIL retry_width idx %0d: got %0d, required %0d", i, width_q[i], SEND_HOLD);
            end
        end
        n_vec++;
        if (count !== '0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL retry_state: count=%0d busy=%b, required 0 1", count, busy);
        end
    endtask

    task automatic test_reset_mid_transfer();
        logic [7:0] bytes[$];
        int waited = 0;
        // Reset while waiting for the UART, with bytes still stored.
        umode = U_STUCK;
        apply_reset();
        for (int i = 0; i < 6; i++) bytes.push_back(8'($urandom_range(0, 255)));
        write_burst(bytes);
        repeat (10) @(negedge clk);
        n_vec++;
        if (busy !== 1'b1 || count !== CW'(5) || send !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_pre: busy=%b count=%0d send=%b, required 1 5 0", busy, count, send);
        end
        #2;
        rst = 1'b1;
        #1;
        n_vec++;
        if (send !== 1'b0 || count !== '0 || empty !== 1'b1 || busy !== 1'b0 || tx_data !== 8'h00) begin
            n_err++;
            $display("FAIL midrst_async: send=%b count=%0d empty=%b busy=%b tx_data=%h, required 0 0 1 0 00",
                     send, count, empty, busy, tx_data);
        end
        umode = U_NORMAL;
        repeat (2) @(negedge clk);
        clear_logs();
        rst = 1'b0;
        repeat (50) @(negedge clk);
        n_vec++;
        if (rx_q.size() != 0 || count !== '0) begin
            n_err++;
            $display("FAIL midrst_after: %0d sends count=%0d, required 0 0", rx_q.size(), count);
        end
        // Reset while send is high: send must drop without waiting for an edge.
        @(negedge clk);
        wr_en   = 1'b1;
        wr_data = 8'h5A;
        @(negedge clk);
        wr_en = 1'b0;
        while (send !== 1'b1 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        #2;
        rst = 1'b1;
        #1;
        n_vec++;
        if (send !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_send_drop: send=%b, required 0", send);
        end
        repeat (2) @(negedge clk);
        clear_logs();
        rst = 1'b0;
    endtask

    task automatic test_full_push_pop();
        logic [7:0] bytes[$];
        int waited = 0;
        umode = U_STUCK;
        apply_reset();
        for (int i = 0; i <= DEPTH; i++) bytes.push_back(8'($urandom_range(0, 255)));
        write_burst(bytes);
        n_vec++;
        if (count !== CW'(DEPTH) || full !== 1'b1) begin
            n_err++;
            $display("FAIL fpp_full: count=%0d full=%b, required %0d 1", count, full, DEPTH);
        end
        umode    = U_NORMAL;
        busy_len = 10;
        while (busy !== 1'b0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        // The FSM is now in IDLE with a full FIFO, so the next edge pops.
        // A write at that same edge must be dropped.
        n_vec++;
        if (busy !== 1'b0 || count !== CW'(DEPTH)) begin
            n_err++;
            $display("FAIL fpp_idle_full: busy=%b count=%0d, required 0 %0d", busy, count, DEPTH);
        end
        wr_en   = 1'b1;
        wr_data = ~bytes[DEPTH];
        @(negedge clk);
        wr_en = 1'b0;
        n_vec++;
        if (count !== CW'(DEPTH - 1) || full !== 1'b0 || send !== 1'b1) begin
            n_err++;
            $display("FAIL fpp_count: count=%0d full=%b send=%b, required %0d 0 1", count, full, send, DEPTH - 1);
        end
`ifdef FEEDER_OVERFLOW_FLAG_EN
        n_vec++;
        if (overflow !== 1'b1) begin
            n_err++;
            $display("FAIL fpp_overflow: got %b, required 1", overflow);
        end
`endif
        wait_rx(DEPTH + 1, (DEPTH + 1) * 40, "fpp_drain");
        repeat (40) @(negedge clk);
        n_vec++;
        if (rx_q.size() != DEPTH + 1) begin
            n_err++;
            $display("FAIL fpp_tx_count: %0d bytes, required %0d", rx_q.size(), DEPTH + 1);
        end
        for (int i = 0; i < rx_q.size() && i <= DEPTH; i++) begin
            n_vec++;
            if (rx_q[i] !== bytes[i]) begin
                n_err++;
                $display("FAIL fpp_order idx %0d: got %h, required %h", i, rx_q[i], bytes[i]);
            end
        end
    endtask

    task automatic test_random();
        umode = U_NORMAL;
        apply_reset();
        for (int batch = 0; batch < 4; batch++) begin
            logic [7:0] exp_q[$];
            int n;
            busy_len = $urandom_range(4, 20);
            n        = $urandom_range(1, DEPTH);
            clear_logs();
            // At most DEPTH bytes per batch, so no write can ever be dropped.
            for (int i = 0; i < n; i++) begin
                int gap = $urandom_range(0, 3);
                repeat (gap) begin
                    @(negedge clk);
                    wr_en = 1'b0;
                end
                @(negedge clk);
                wr_en   = 1'b1;
                wr_data = 8'($urandom_range(0, 255));
                exp_q.push_back(wr_data);
            end
            @(negedge clk);
            wr_en = 1'b0;
            wait_rx(n, n * (busy_len + SEND_HOLD + 10) + 50, "rand_drain");
            repeat (busy_len + 10) @(negedge clk);
            n_vec++;
            if (rx_q.size() != n || empty !== 1'b1 || count !== '0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL rand_batch %0d: sent=%0d empty=%b count=%0d busy=%b, required %0d 1 0 0",
                         batch, rx_q.size(), empty, count, busy, n);
            end
            for (int i = 0; i < rx_q.size() && i < n; i++) begin
                n_vec++;
                if (rx_q[i] !== exp_q[i]) begin
                    n_err++;
                    $display("FAIL rand_data b%0d idx %0d: got %h, required %h", batch, i, rx_q[i], exp_q[i]);
                end
            end
            foreach (width_q[i]) begin
                n_vec++;
                if (width_q[i] != SEND_HOLD) begin
                    n_err++;
                    $display("FAIL rand_width b%0d idx %0d: got %0d, required %0d", batch, i, width_q[i], SEND_HOLD);
                end
            end
        end
    endtask

    initial begin
        rst            = 1'b1;
        wr_en          = 1'b0;
        wr_data        = 8'h00;
        port_available = 1'b1;
        test_reset();
        test_single_byte();
        test_overflow();
        test_timeout_retry();
        test_reset_mid_transfer();
        test_full_push_pop();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
